// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate D-cache, 32-byte lines, line-granular pmem port.
// Latency: a hit gives mem_resp one cycle after the lookup edge; a miss adds pmem wait (plus write-back if dirty).
// Backpressure: requester holds the request until mem_resp; pmem outputs are held until pmem_resp. DCACHE_PERF_CNT_EN adds hit/miss counters.
module dcache_responder #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  perf_hits,
  output logic [31:0]  perf_misses
`endif
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_arr  [SETS];
  logic [255:0]       line_arr [SETS];

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic               req_vld;
  logic               hit;
  logic [255:0]       cur_line;
  logic               unused_addr_bits;

  assign req_tag          = mem_address[31:5+S_INDEX];
  assign req_idx          = mem_address[4+S_INDEX:5];
  assign req_word         = mem_address[4:2];
  assign req_vld          = mem_read | mem_write;
  assign hit              = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign cur_line         = line_arr[req_idx];
  assign unused_addr_bits = ^mem_address[1:0];

  // All outputs decode from the async-reset state, so they drop as soon as rst falls.
  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (req_vld) begin
          if (hit)
            state_nxt = RESP;
          else if (valid_q[req_idx] && dirty_q[req_idx])
            state_nxt = WB;
          else
            state_nxt = FETCH;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[req_idx], req_idx, 5'b0};
        pmem_wdata   = cur_line;
        if (pmem_resp)
          state_nxt = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, 5'b0};
        if (pmem_resp)
          state_nxt = RESP;
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = cur_line[{req_word, 5'b0} +: 32];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == WB && pmem_resp)
        dirty_q[req_idx] <= 1'b0;
      if (state == FETCH && pmem_resp) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (state == RESP && mem_write && (mem_byte_enable != 4'b0))
        dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (state == FETCH && pmem_resp) begin
      line_arr[req_idx] <= pmem_rdata;
      tag_arr[req_idx]  <= req_tag;
    end else if (state == RESP && mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b])
          line_arr[req_idx][{req_word, 2'(b), 3'b000} +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state == IDLE && req_vld) begin
      if (hit)
        perf_hits <= perf_hits + 32'd1;
      else
        perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

  // Simultaneous read and write is a requester bug; the FSM serves it as a write.
  assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write))
    else $error("dcache_responder: mem_read and mem_write asserted together");

endmodule
